// File: rtl/axis_packet_arbiter_if.sv
// axis_packet_arbiter_if: bundles NUM_SRC AXIS source streams and the single merged master stream
//   s_tvalid/s_tready/s_tdata/s_tkeep/s_tlast : flattened per-source streams, source i in slice i
//   m_tvalid/m_tready/m_tdata/m_tkeep/m_tlast : merged stream toward the processor
//   m_tid                                     : index of the source currently granted
//   modport slave  : the arbiter's view; modport master : the environment's view
interface axis_packet_arbiter_if #(
   parameter int NUM_SRC = 4,
   parameter int DATA_WIDTH_BYTES = 1
);
   localparam int IW = $clog2(NUM_SRC);
   logic [NUM_SRC-1:0] s_tvalid, s_tready, s_tlast;
   logic [NUM_SRC*DATA_WIDTH_BYTES*8-1:0] s_tdata;
   logic [NUM_SRC*DATA_WIDTH_BYTES-1:0] s_tkeep;
   logic m_tvalid, m_tready, m_tlast;
   logic [DATA_WIDTH_BYTES*8-1:0] m_tdata;
   logic [DATA_WIDTH_BYTES-1:0] m_tkeep;
   logic [IW-1:0] m_tid;
   modport slave (
      input  s_tvalid, s_tdata, s_tkeep, s_tlast, m_tready,
      output s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tid
   );
   modport master (
      output s_tvalid, s_tdata, s_tkeep, s_tlast, m_tready,
      input  s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tid
   );
endinterface

// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: packet-atomic round-robin merge of NUM_SRC AXIS streams onto one master stream
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   en        : allows new grants; never interrupts a packet in flight
//   bus       : source and master AXIS streams plus m_tid (slave modport)
//   busy      : high while a packet is locked
//   pkt_count : completed packets, all sources, wraps silently
module axis_packet_arbiter #(
   parameter int NUM_SRC = 4,
   parameter int DATA_WIDTH_BYTES = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   axis_packet_arbiter_if.slave bus,
   output logic busy,
   output logic [15:0] pkt_count
);
   localparam int IW = $clog2(NUM_SRC);
   localparam int DW = DATA_WIDTH_BYTES * 8;
   typedef enum logic {IDLE, LOCK} state_t;
   state_t state, state_nxt;
   logic [IW-1:0] grant, rr_ptr, pick;
   logic found, done;
   // scan downward so the lowest offset from rr_ptr wins; modulo keeps non-power-of-two counts in range
   always_comb begin
      pick = rr_ptr;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         int j;
         j = (int'(rr_ptr) + k) % NUM_SRC;
         if (bus.s_tvalid[j]) pick = IW'(j);
      end
   end
   assign found = |bus.s_tvalid;
   assign done = state == LOCK && bus.m_tvalid && bus.m_tready && bus.m_tlast;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         rr_ptr <= '0;
         pkt_count <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && en && found) grant <= pick;
         if (done) begin
            rr_ptr <= (grant == IW'(NUM_SRC - 1)) ? '0 : grant + 1'b1;
            pkt_count <= pkt_count + 16'd1;
         end
      end
   end
   always_comb begin
      state_nxt = state;
      if (state == IDLE) state_nxt = (en && found) ? LOCK : IDLE;
      else if (done) state_nxt = IDLE;
   end
   always_comb begin
      busy = state == LOCK;
      bus.m_tid = grant;
      bus.m_tvalid = busy && bus.s_tvalid[grant];
      bus.m_tdata = bus.s_tdata[int'(grant)*DW +: DW];
      bus.m_tkeep = bus.s_tkeep[int'(grant)*DATA_WIDTH_BYTES +: DATA_WIDTH_BYTES];
      bus.m_tlast = bus.s_tlast[grant];
      bus.s_tready = (busy && bus.m_tready) ? NUM_SRC'(1) << grant : '0;
   end
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb_axis_packet_arbiter: directed checks of grant order, packet atomicity, stalls, en, reset and counter wrap
module tb_axis_packet_arbiter;
   logic clk = 1'b0, rst = 1'b1, en = 1'b1;
   logic busy, busy3;
   logic [15:0] pkt_count, pkt_count3;
   int n_vec = 0, n_bad = 0;
   int npk[4], plen[4], beat[4], seq[4];
   logic [3:0] hold = '0;
   axis_packet_arbiter_if #(.NUM_SRC(4), .DATA_WIDTH_BYTES(1)) bus ();
   axis_packet_arbiter_if #(.NUM_SRC(3), .DATA_WIDTH_BYTES(1)) bus3 ();
   axis_packet_arbiter #(.NUM_SRC(4), .DATA_WIDTH_BYTES(1)) dut (
      .clk(clk), .rst(rst), .en(en), .bus(bus), .busy(busy), .pkt_count(pkt_count)
   );
   axis_packet_arbiter #(.NUM_SRC(3), .DATA_WIDTH_BYTES(1)) dut3 (
      .clk(clk), .rst(rst), .en(en), .bus(bus3), .busy(busy3), .pkt_count(pkt_count3)
   );
   always #5 clk = ~clk;
   assign bus3.s_tvalid = 3'b111;
   assign bus3.s_tlast = 3'b111;
   assign bus3.s_tdata = '0;
   assign bus3.s_tkeep = '1;
   assign bus3.m_tready = 1'b1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         bus.s_tvalid[i] = npk[i] != 0 && !hold[i];
         bus.s_tdata[i*8 +: 8] = 8'(i * 16 + seq[i]);
         bus.s_tkeep[i] = ~seq[i][0];
         bus.s_tlast[i] = beat[i] == plen[i] - 1;
      end
   endtask

   task automatic load(input int i, input int n, input int len);
      npk[i] = n;
      plen[i] = len;
      beat[i] = 0;
      seq[i] = 0;
      drive();
   endtask

   // one clock: sample handshakes, advance sources after the edge, settle at the falling edge
   task automatic tick();
      logic [3:0] fire;
      fire = bus.s_tvalid & bus.s_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++)
         if (fire[i]) begin
            seq[i]++;
            if (beat[i] == plen[i] - 1) begin
               beat[i] = 0;
               npk[i]--;
            end else beat[i]++;
         end
      drive();
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         npk[i] = 0; plen[i] = 1; beat[i] = 0; seq[i] = 0;
      end
      bus.m_tready = 1'b1;
      drive();
      tick();
      tick();
      chk("rst busy", 32'(busy), 0);
      chk("rst m_tvalid", 32'(bus.m_tvalid), 0);
      chk("rst m_tid", 32'(bus.m_tid), 0);
      chk("rst pkt_count", 32'(pkt_count), 0);
      chk("rst s_tready", 32'(bus.s_tready), 0);
      chk("rst m_tid3", 32'(bus3.m_tid), 0);

      // two 3-beat packets on sources 0 and 2
      rst = 1'b0;
      load(0, 1, 3);
      load(2, 1, 3);
      chk("s1 idle before grant", 32'(bus.m_tvalid), 0);
      tick();
      for (int b = 0; b < 3; b++) begin
         chk("s1 tid0", 32'(bus.m_tid), 0);
         chk("s1 tdata0", 32'(bus.m_tdata), 32'(b));
         chk("s1 tkeep0", 32'(bus.m_tkeep), 32'(b % 2 == 0));
         chk("s1 tlast0", 32'(bus.m_tlast), 32'(b == 2));
         chk("s1 s_tready0", 32'(bus.s_tready), 1);
         tick();
      end
      chk("s1 gap busy", 32'(busy), 0);
      chk("s1 gap m_tvalid", 32'(bus.m_tvalid), 0);
      chk("s1 pkt1", 32'(pkt_count), 1);
      tick();
      for (int b = 0; b < 3; b++) begin
         chk("s1 tid2", 32'(bus.m_tid), 2);
         chk("s1 tdata2", 32'(bus.m_tdata), 32'(8'h20 + b));
         tick();
      end
      chk("s1 pkt2", 32'(pkt_count), 2);

      // all sources streaming 1-beat packets; NUM_SRC=3 instance runs alongside
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) load(i, 2, 1);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("s2 tid", 32'(bus.m_tid), 32'(k % 4));
         chk("s2 m_tvalid", 32'(bus.m_tvalid), 1);
         chk("s2 tid3", 32'(bus3.m_tid), 32'(k % 3));
         chk("s2 busy3", 32'(busy3), 1);
         tick();
         chk("s2 gap busy", 32'(busy), 0);
         chk("s2 pkt", 32'(pkt_count), 32'(k + 1));
      end

      // source 1 4-beat packet under alternating m_tready, source 3 waiting
      load(1, 1, 4);
      load(3, 1, 2);
      tick();
      for (int c = 0; c < 7; c++) begin
         bus.m_tready = c % 2 == 0;
         #1;
         chk("s3 tid", 32'(bus.m_tid), 1);
         chk("s3 tdata", 32'(bus.m_tdata), 32'(8'h10 + (c + 1) / 2));
         chk("s3 tlast", 32'(bus.m_tlast), 32'(c >= 5));
         chk("s3 s_tready", 32'(bus.s_tready), (c % 2 == 0) ? 32'h2 : 32'h0);
         tick();
      end
      bus.m_tready = 1'b1;
      chk("s3 idle", 32'(busy), 0);
      chk("s3 pkt", 32'(pkt_count), 9);
      tick();
      chk("s3 tid3", 32'(bus.m_tid), 3);
      chk("s3 tdata3", 32'(bus.m_tdata), 32'h30);
      tick();
      chk("s3 tlast3", 32'(bus.m_tlast), 1);
      tick();
      chk("s3 pkt2", 32'(pkt_count), 10);

      // en dropped mid-packet
      load(0, 1, 3);
      load(1, 1, 1);
      tick();
      tick();
      en = 1'b0;
      #1;
      chk("s4 beat2 tdata", 32'(bus.m_tdata), 32'h01);
      tick();
      chk("s4 beat3 tid", 32'(bus.m_tid), 0);
      chk("s4 beat3 tdata", 32'(bus.m_tdata), 32'h02);
      chk("s4 beat3 busy", 32'(busy), 1);
      tick();
      chk("s4 idle busy", 32'(busy), 0);
      chk("s4 pkt", 32'(pkt_count), 11);
      tick();
      chk("s4 held busy", 32'(busy), 0);
      chk("s4 held m_tvalid", 32'(bus.m_tvalid), 0);
      en = 1'b1;
      tick();
      chk("s4 regrant busy", 32'(busy), 1);
      chk("s4 regrant tid", 32'(bus.m_tid), 1);
      chk("s4 regrant tdata", 32'(bus.m_tdata), 32'h10);
      tick();
      chk("s4 pkt2", 32'(pkt_count), 12);

      // source bubble mid-packet
      load(2, 1, 2);
      tick();
      tick();
      hold[2] = 1'b1;
      drive();
      #1;
      chk("bub m_tvalid", 32'(bus.m_tvalid), 0);
      chk("bub busy", 32'(busy), 1);
      tick();
      chk("bub hold busy", 32'(busy), 1);
      chk("bub hold tid", 32'(bus.m_tid), 2);
      hold[2] = 1'b0;
      drive();
      #1;
      chk("bub resume tdata", 32'(bus.m_tdata), 32'h21);
      chk("bub resume tlast", 32'(bus.m_tlast), 1);
      tick();
      chk("bub pkt", 32'(pkt_count), 13);

      // reset pulse during beat 2 of a 5-beat packet
      load(3, 1, 5);
      tick();
      tick();
      chk("s5 beat2", 32'(bus.m_tdata), 32'h31);
      rst = 1'b1;
      load(0, 1, 1);
      tick();
      chk("s5 m_tvalid", 32'(bus.m_tvalid), 0);
      chk("s5 pkt", 32'(pkt_count), 0);
      chk("s5 tid", 32'(bus.m_tid), 0);
      chk("s5 busy", 32'(busy), 0);
      rst = 1'b0;
      tick();
      chk("s5 regrant tid", 32'(bus.m_tid), 0);
      chk("s5 regrant tdata", 32'(bus.m_tdata), 32'h00);
      npk[3] = 0;
      drive();
      tick();
      chk("s5 pkt1", 32'(pkt_count), 1);

      // counter wrap
      force dut.pkt_count = 16'hffff;
      #1;
      release dut.pkt_count;
      load(1, 2, 1);
      tick();
      tick();
      chk("wrap 0000", 32'(pkt_count), 0);
      tick();
      tick();
      chk("wrap 0001", 32'(pkt_count), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/axis_packet_arbiter.md
AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of AXIS source streams feeding the processor input (legal range 2..8).
REQ-002 SHALL have parameter DATA_WIDTH_BYTES, default 1, tdata width in bytes on every slave port and on the master port.
REQ-003 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port en  input  1  arbitration enable; 0 blocks new grants only.
REQ-006 SHALL have port s_tvalid  input  NUM_SRC  per-source valid.
REQ-007 SHALL have port s_tready  output  NUM_SRC  per-source ready.
REQ-008 SHALL have port s_tdata  input  NUM_SRC*DATA_WIDTH_BYTES*8  flattened source data; source i occupies slice i.
REQ-009 SHALL have port s_tkeep  input  NUM_SRC*DATA_WIDTH_BYTES  flattened byte-keep.
REQ-010 SHALL have port s_tlast  input  NUM_SRC  per-source end-of-packet.
REQ-011 SHALL have port m_tvalid  output  1  master valid toward the processor.
REQ-012 SHALL have port m_tready  input  1  master ready from the processor.
REQ-013 SHALL have port m_tdata  output  DATA_WIDTH_BYTES*8  granted source data.
REQ-014 SHALL have port m_tkeep  output  DATA_WIDTH_BYTES  granted source keep.
REQ-015 SHALL have port m_tlast  output  1  granted source tlast.
REQ-016 SHALL have port m_tid  output  $clog2(NUM_SRC)  index of the currently granted source.
REQ-017 SHALL have port busy  output  1  high while in the LOCK state.
REQ-018 SHALL have port pkt_count  output  16  count of completed packets, all sources combined.

Function
REQ-019 SHALL implement the FSM states IDLE and LOCK.
REQ-020 IDLE: all s_tready=0; m_tvalid=0.
REQ-021 IDLE with en=1 and any s_tvalid=1: select the first asserted source scanning from rr_ptr upward, modulo NUM_SRC.
  - Register the selection into grant.
  - Enter LOCK on the next edge.
  - Arbitration latency is exactly 1 cycle.
REQ-022 IDLE with en=0 or no s_tvalid: remain in IDLE; grant and rr_ptr hold.
REQ-023 LOCK: the datapath from source grant to the master port SHALL be combinational.
  - m_tvalid=s_tvalid[grant].
  - m_tdata, m_tkeep and m_tlast SHALL equal the grant slices.
  - s_tready[grant]=m_tready; all other s_tready=0.
REQ-024 A beat transfers when m_tvalid and m_tready are both 1.
  - In LOCK, a transferred beat with m_tlast=1 SHALL return the FSM to IDLE on the next edge.
  - The same edge SHALL set rr_ptr=(grant+1) mod NUM_SRC, wrapping NUM_SRC-1 to 0.
  - The same edge SHALL increment pkt_count.
REQ-025 Grant SHALL be packet-atomic: no source switch occurs before the tlast beat transfers, whatever the other requests.
REQ-026 en deassertion during LOCK SHALL NOT interrupt the current packet; it blocks only the next grant.
REQ-027 s_tvalid[grant]=0 mid-packet (source bubble) SHALL hold LOCK with m_tvalid=0.
REQ-028 m_tready=0 SHALL stall the granted source; m_tdata, m_tkeep and m_tlast follow the source, which holds them per AXIS rules.
REQ-029 A single-beat packet (tlast on the first beat) SHALL occupy exactly 1 LOCK cycle if m_tready=1.
  - The next grant appears on m_tvalid no earlier than 2 cycles after that beat.
REQ-030 pkt_count SHALL wrap 0xFFFF -> 0x0000 with no flag.
REQ-031 m_tid SHALL equal grant in every state; busy=1 exactly in LOCK.
REQ-032 NUM_SRC values that are not powers of two SHALL wrap rr_ptr correctly and never grant an index >= NUM_SRC.

Reset
REQ-033 rst=1 on a clock edge SHALL force the following on that edge:
  - state=IDLE, grant=0, rr_ptr=0, pkt_count=0.
  - All s_tready=0, m_tvalid=0, busy=0, m_tid=0.
REQ-034 rst asserted mid-packet SHALL abandon the packet with no drain or completion.
  - The remainder is not forwarded as the same packet.
  - pkt_count is not incremented.
REQ-035 Arbitration SHALL resume on the first edge after rst falls; after rst, source 0 has highest priority.

Verification
REQ-036 Scenario: after reset, sources 0 and 2 each present a 3-beat packet, m_tready=1 -> m_tid=0 for beats 1-3, then 1 idle cycle, then m_tid=2 for beats 1-3; pkt_count=2.
REQ-037 Scenario: all 4 sources continuously valid with 1-beat packets -> grants cycle 0,1,2,3,0,..., each spaced 2 cycles apart; pkt_count=8 after 16 cycles.
REQ-038 Scenario: source 1 locked on a 4-beat packet, m_tready toggles 1,0,1,0,... and source 3 is valid throughout -> no source-3 beat before the source-1 tlast beat, and all 4 source-1 beats delivered in order.
REQ-039 Scenario: en driven to 0 during beat 2 of a 3-beat packet -> beat 3 completes; then IDLE with busy=0 while sources stay valid; en=1 -> grant 1 cycle later.
REQ-040 Scenario: rst pulsed for 1 cycle during beat 2 of a 5-beat packet -> m_tvalid=0, pkt_count=0, m_tid=0 the next cycle; next grant goes to source 0 if it is valid.
REQ-041 Scenario: pkt_count preloaded near wrap by sending 65537 one-beat packets -> reads 0x0001.
